// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, coordinate/colour types and a range helper.
package vga_timing_pkg;

   localparam int unsigned H_VISIBLE = 640;
   localparam int unsigned H_FRONT   = 16;
   localparam int unsigned H_SYNC    = 96;
   localparam int unsigned H_BACK    = 48;
   localparam int unsigned V_VISIBLE = 480;
   localparam int unsigned V_FRONT   = 10;
   localparam int unsigned V_SYNC    = 2;
   localparam int unsigned V_BACK    = 33;

   localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
   localparam int unsigned HS_END   = HS_START + H_SYNC;
   localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
   localparam int unsigned VS_END   = VS_START + V_SYNC;

   localparam logic SYNC_ACTIVE_LOW = 1'b0;

   typedef logic [10:0] coord_t;
   typedef logic [7:0]  rgb332_t;

   // Half-open interval test, lo <= v < hi, all unsigned 11-bit.
   function automatic logic in_range(input coord_t v, input coord_t lo, input coord_t hi);
      return (v >= lo) && (v < hi);
   endfunction

endpackage

// File: rtl/vga_scan_timing_if.sv
// Scan position out to the renderer, show/colour back in, and the VGA pins.
interface vga_scan_timing_if;
   import vga_timing_pkg::*;

   logic    show;
   rgb332_t fg_color;
   rgb332_t bg_color;
   coord_t  x;
   coord_t  y;
   logic    pix_en;
   logic    hsync;
   logic    vsync;
   rgb332_t rgb;
   logic    frame_start;

   modport master (
      input  show, fg_color, bg_color,
      output x, y, pix_en, hsync, vsync, rgb, frame_start
   );

   modport slave (
      output show, fg_color, bg_color,
      input  x, y, pix_en, hsync, vsync, rgb, frame_start
   );

endinterface

// File: rtl/vga_axis_counter.sv
// Wrapping 0..TOTAL-1 axis counter; wrap flags the last count (combinational).
// Latency: count updates on the clk edge where en is high.
// Backpressure: none; en=0 simply holds the count.
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int unsigned TOTAL = H_TOTAL
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   en,
   output coord_t count,
   output logic   wrap
);

   localparam coord_t LAST = coord_t'(TOTAL - 1);

   assign wrap = (count == LAST);

   always_ff @(posedge clk) begin
      if (!rst) begin
         count <= '0;
      end else if (en) begin
         count <= wrap ? '0 : count + 11'd1;
      end
   end

endmodule

// File: rtl/vga_scan_timing.sv
// VGA scan counters plus registered sync/colour stage; VGA_PIXDIV_EN halves the pixel rate.
// Latency: hsync/vsync/rgb lag (x, y, show) by one pixel; frame_start coincides with (0,0).
// Backpressure: none; everything advances on pix_en.
module vga_scan_timing
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_VISIBLE   = vga_timing_pkg::H_VISIBLE,
   parameter int unsigned H_FRONT     = vga_timing_pkg::H_FRONT,
   parameter int unsigned H_SYNC      = vga_timing_pkg::H_SYNC,
   parameter int unsigned H_BACK      = vga_timing_pkg::H_BACK,
   parameter int unsigned V_VISIBLE   = vga_timing_pkg::V_VISIBLE,
   parameter int unsigned V_FRONT     = vga_timing_pkg::V_FRONT,
   parameter int unsigned V_SYNC      = vga_timing_pkg::V_SYNC,
   parameter int unsigned V_BACK      = vga_timing_pkg::V_BACK,
   parameter logic        SYNC_ACTIVE = SYNC_ACTIVE_LOW
) (
   input  logic              clk,
   input  logic              rst,
   vga_scan_timing_if.master vga
);

   localparam int unsigned H_TOT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam coord_t H_VIS_C = coord_t'(H_VISIBLE);
   localparam coord_t V_VIS_C = coord_t'(V_VISIBLE);
   localparam coord_t HS_LO   = coord_t'(H_VISIBLE + H_FRONT);
   localparam coord_t HS_HI   = coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam coord_t VS_LO   = coord_t'(V_VISIBLE + V_FRONT);
   localparam coord_t VS_HI   = coord_t'(V_VISIBLE + V_FRONT + V_SYNC);

   logic    pix_en;
   coord_t  x_cnt;
   coord_t  y_cnt;
   logic    x_wrap;
   logic    y_wrap;
   logic    y_en;
   rgb332_t rgb_nxt;

`ifdef VGA_PIXDIV_EN
   logic pix_div;

   always_ff @(posedge clk) begin
      if (!rst) begin
         pix_div <= 1'b0;
      end else begin
         pix_div <= ~pix_div;
      end
   end

   assign pix_en = pix_div;
`else
   assign pix_en = 1'b1;
`endif

   assign y_en = x_wrap & pix_en;

   vga_axis_counter #(.TOTAL(H_TOT)) u_x_cnt (
      .clk   (clk),
      .rst   (rst),
      .en    (pix_en),
      .count (x_cnt),
      .wrap  (x_wrap)
   );

   vga_axis_counter #(.TOTAL(V_TOT)) u_y_cnt (
      .clk   (clk),
      .rst   (rst),
      .en    (y_en),
      .count (y_cnt),
      .wrap  (y_wrap)
   );

   // Blanking is decided here so the renderer never needs to clamp coordinates.
   always_comb begin
      rgb_nxt = 8'h00;
      if ((x_cnt < H_VIS_C) && (y_cnt < V_VIS_C)) begin
         rgb_nxt = vga.show ? vga.fg_color : vga.bg_color;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         vga.hsync       <= ~SYNC_ACTIVE;
         vga.vsync       <= ~SYNC_ACTIVE;
         vga.rgb         <= 8'h00;
         vga.frame_start <= 1'b0;
      end else begin
         vga.frame_start <= pix_en & x_wrap & y_wrap;
         if (pix_en) begin
            vga.hsync <= in_range(x_cnt, HS_LO, HS_HI) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vga.vsync <= in_range(y_cnt, VS_LO, VS_HI) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vga.rgb   <= rgb_nxt;
         end
      end
   end

   assign vga.x      = x_cnt;
   assign vga.y      = y_cnt;
   assign vga.pix_en = pix_en;

endmodule

// File: tb/tb_vga_scan_timing.sv
// Directed bench: full 800-pixel lines, vertical shortened to 15 lines so whole frames fit the run.
module tb_vga_scan_timing;
   import vga_timing_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad = 0;

   vga_scan_timing_if bus ();

   // V_TOTAL = 8+2+2+3 = 15 lines, vsync on y=10..11, frame = 12000 pixels.
   vga_scan_timing #(
      .V_VISIBLE (8),
      .V_FRONT   (2),
      .V_SYNC    (2),
      .V_BACK    (3)
   ) dut (
      .clk (clk),
      .rst (rst),
      .vga (bus)
   );

   always #10 clk = ~clk;

   always_comb bus.show = (bus.x == 11'd100) || (bus.x >= 11'd640);

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_xy(input string tag, input int wx, input int wy, input int bound);
      int n = 0;
      while (!((int'(bus.x) == wx) && (wy < 0 || int'(bus.y) == wy)) && n < bound) begin
         step();
         n++;
      end
      chk({tag, "_reached"}, int'(n < bound), 1);
   endtask

   initial begin
      int n;
      int y0;
      int px;
      int py;
      int vlow;
      int fs_cnt;
      int y_bad;

      bus.fg_color = 8'hE0;
      bus.bg_color = 8'h03;
      rst = 1'b0;
      repeat (3) step();
      chk("rst_x", bus.x, 0);
      chk("rst_y", bus.y, 0);
      chk("rst_hsync", bus.hsync, 1);
      chk("rst_vsync", bus.vsync, 1);
      chk("rst_rgb", bus.rgb, 0);
      chk("rst_fs", bus.frame_start, 0);

`ifdef VGA_PIXDIV_EN
      chk("div_rst_pix_en", bus.pix_en, 0);
      rst = 1'b1;
      step();
      chk("div_pix_en_1", bus.pix_en, 1);
      chk("div_x_hold", bus.x, 0);
      step();
      chk("div_pix_en_0", bus.pix_en, 0);
      chk("div_x_1", bus.x, 1);
      step();
      chk("div_x_1b", bus.x, 1);
      step();
      chk("div_x_2", bus.x, 2);

      wait_xy("div_x656", 656, -1, 3000);
      n = 0;
      while (bus.hsync == 1'b1 && n < 400) begin step(); n++; end
      n = 0;
      while (bus.hsync == 1'b0 && n < 1000) begin step(); n++; end
      chk("div_hsync_low_clks", n, 192);

      wait_xy("div_x0", 0, -1, 4000);
      n = 0;
      while (bus.x == 11'd0 && n < 4000) begin step(); n++; end
      while (bus.x != 11'd0 && n < 4000) begin step(); n++; end
      chk("div_line_clks", n, 1600);
`else
      chk("pix_en_tied", bus.pix_en, 1);
      rst = 1'b1;
      repeat (10) step();
      chk("run10_x", bus.x, 10);
      chk("run10_y", bus.y, 0);

      wait_xy("x100", 100, -1, 1000);
      chk("rgb_before_fg", bus.rgb, 8'h03);
      step();
      chk("rgb_fg", bus.rgb, 8'hE0);
      step();
      chk("rgb_after_fg", bus.rgb, 8'h03);

      wait_xy("x641", 641, -1, 1000);
      chk("rgb_blank_640", bus.rgb, 0);
      wait_xy("x656", 656, -1, 1000);
      chk("hsync_pre", bus.hsync, 1);
      chk("rgb_blank_656", bus.rgb, 0);
      step();
      chk("hsync_assert", bus.hsync, 0);
      n = 0;
      while (bus.hsync == 1'b0 && n < 2000) begin step(); n++; end
      chk("hsync_low_pixels", n, 96);
      chk("hsync_release_x", bus.x, 753);

      wait_xy("x0", 0, -1, 1000);
      y0 = bus.y;
      step();
      n = 1;
      while (bus.x != 11'd0 && n < 2000) begin step(); n++; end
      chk("line_period", n, 800);
      chk("line_y_inc", bus.y, y0 + 1);

      n = 0;
      while (bus.frame_start != 1'b1 && n < 20000) begin step(); n++; end
      chk("fs_seen", int'(n < 20000), 1);
      chk("fs_x", bus.x, 0);
      chk("fs_y", bus.y, 0);

      n = 0; vlow = 0; fs_cnt = 0; y_bad = 0;
      do begin
         px = bus.x;
         py = bus.y;
         step();
         n++;
         if (bus.vsync == 1'b0) vlow++;
         if (bus.frame_start == 1'b1) fs_cnt++;
         if (int'(bus.y) != py && px != 799) y_bad++;
      end while (bus.frame_start != 1'b1 && n < 20000);
      chk("frame_period", n, 12000);
      chk("vsync_low_clks", vlow, 1600);
      chk("fs_per_frame", fs_cnt, 1);
      chk("y_step_only_at_wrap", y_bad, 0);
      step();
      chk("fs_one_clk", bus.frame_start, 0);

      wait_xy("mid", 700, 11, 20000);
      chk("mid_hsync", bus.hsync, 0);
      chk("mid_vsync", bus.vsync, 0);
      rst = 1'b0;
      step();
      chk("mid_rst_x", bus.x, 0);
      chk("mid_rst_y", bus.y, 0);
      chk("mid_rst_hsync", bus.hsync, 1);
      chk("mid_rst_vsync", bus.vsync, 1);
      chk("mid_rst_rgb", bus.rgb, 0);
      chk("mid_rst_fs", bus.frame_start, 0);
      rst = 1'b1;
      step();
      chk("post_rst_x", bus.x, 1);
      chk("post_rst_fs", bus.frame_start, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
